// File: rtl/wave_table_loader.sv
// Framed byte-stream loader for the 1024 x 14 waveform RAM: parses sync/address/count,
// writes one sample per WRITE cycle, then verifies an 8-bit additive checksum.
module wave_table_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 14,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam logic [15:0] MAX_N = 16'(1 << ADDR_W);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_SAMP_H, S_SAMP_L, S_WRITE, S_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic               running_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         addr_hi_q, cnt_hi_q, samp_hi_q, csum_q;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic [CNT_W-1:0]   remain_q;

    logic               accept, sync_seen, tmo_hit, fin, fin_err;
    logic [15:0]        n_full;

    // in_ready comes from registers only; running_q keeps it low until the first edge after reset
    assign in_ready  = running_q && (state_q != S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign sync_seen = (state_q == S_IDLE) && accept && (in_data == SYNC);
    assign n_full    = {cnt_hi_q, in_data};
    assign tmo_hit   = (state_q != S_IDLE) && (state_q != S_WRITE) && !accept &&
                       (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fin     = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            S_IDLE:   if (sync_seen) state_d = S_ADDR_H;
            S_ADDR_H: if (accept) state_d = S_ADDR_L;
            S_ADDR_L: if (accept) state_d = S_CNT_H;
            S_CNT_H:  if (accept) state_d = S_CNT_L;
            S_CNT_L: begin
                if (accept) begin
                    if (n_full > MAX_N) begin
                        state_d = S_IDLE;
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        state_d = S_SAMP_H;
                    end
                end
            end
            S_SAMP_H: if (accept) state_d = S_SAMP_L;
            S_SAMP_L: if (accept) state_d = S_WRITE;
            S_WRITE:  state_d = (remain_q == CNT_W'(1)) ? S_CSUM : S_SAMP_H;
            S_CSUM: begin
                if (accept) begin
                    state_d = S_IDLE;
                    fin     = 1'b1;
                    fin_err = (in_data != csum_q);
                end
            end
            default:  state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = S_IDLE;
            fin     = 1'b1;
            fin_err = 1'b1;
        end
    end

    // Registered outputs; wr_addr/wr_data only move on the edge that raises wr_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            tmo_q     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            running_q <= 1'b1;
            done      <= fin;
            wr_en     <= (state_q == S_SAMP_L) && accept;
            if (fin_err) begin
                err <= 1'b1;
            end else if (sync_seen) begin
                err <= 1'b0;
            end
            if (accept || state_q == S_IDLE || state_q == S_WRITE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if ((state_q == S_SAMP_L) && accept) begin
                wr_addr <= cur_addr_q;
                wr_data <= DATA_W'({samp_hi_q, in_data});
            end
        end
    end

    // Frame datapath: loaded before use within a frame, so no reset needed
    always_ff @(posedge clk) begin
        if (sync_seen) begin
            csum_q <= 8'h00;
        end else if (accept && (state_q inside {S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
                                                S_SAMP_H, S_SAMP_L})) begin
            csum_q <= csum_q + in_data;
        end
        if (accept) begin
            case (state_q)
                S_ADDR_H: addr_hi_q  <= in_data;
                S_ADDR_L: cur_addr_q <= ADDR_W'({addr_hi_q, in_data});
                S_CNT_H:  cnt_hi_q   <= in_data;
                S_CNT_L:  remain_q   <= (n_full == 16'd0) ? CNT_W'(MAX_N) : n_full[CNT_W-1:0];
                S_SAMP_H: samp_hi_q  <= in_data;
                default:  ;
            endcase
        end
        if (state_q == S_WRITE) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            remain_q   <= remain_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wave_table_loader.sv
// Scoreboard bench for wave_table_loader: expected RAM writes and done/err outcomes are
// queued as frames are driven and matched against the DUT outputs on the falling edge.
module tb_wave_table_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, busy, done, err;
    logic [9:0]  wr_addr;
    logic [13:0] wr_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          rdy_low = 0;
    int          wr_seen = 0;
    logic        done_d = 1'b0;
    logic [1:0]  pad = 2'b00;
    logic [13:0] samp_buf [1024];
    logic [23:0] exp_wr [$];
    bit          exp_done [$];

    wave_table_loader #(.ADDR_W(10), .DATA_W(14), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: compare writes and done pulses against the scoreboard queues
    always @(negedge clk) begin
        logic [23:0] e;
        bit          ee;
        if (rst_n) begin
            if (wr_en) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("stray_wr", 1, 0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", wr_addr, e[23:14]);
                    check("wr_data", wr_data, e[13:0]);
                end
            end
            if (!in_ready) rdy_low++;
            if (done) begin
                check("busy_at_done", busy, 0);
                if (exp_done.size() == 0) begin
                    check("stray_done", 1, 0);
                end else begin
                    ee = exp_done.pop_front();
                    check("done_err", err, ee);
                end
            end
            if (done && done_d) check("done_1cyc", 1, 0);
            done_d = done;
        end else begin
            done_d = 1'b0;
        end
    end

    // All driving happens 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("rdy_wait", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [9:0] addr, input logic [15:0] n,
                              input logic [7:0] delta, input bit skip_sync);
        logic [7:0] cs, h, l;
        logic [7:0] hdr [4];
        int         cnt;
        cs = 8'h00;
        hdr[0] = {6'b0, addr[9:8]};
        hdr[1] = addr[7:0];
        hdr[2] = n[15:8];
        hdr[3] = n[7:0];
        if (n > 16'd1024) exp_done.push_back(1'b1);
        if (!skip_sync) send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            send_byte(hdr[i]);
            cs = cs + hdr[i];
        end
        if (n > 16'd1024) return;
        cnt = (n == 16'd0) ? 1024 : int'(n);
        for (int i = 0; i < cnt; i++) begin
            h = {pad, samp_buf[i][13:8]};
            l = samp_buf[i][7:0];
            exp_wr.push_back({addr + 10'(i), samp_buf[i]});
            send_byte(h);
            send_byte(l);
            cs = cs + h + l;
        end
        exp_done.push_back(delta != 8'h00);
        send_byte(cs + delta);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", in_ready, 1);

        // Good frame: in_ready drops only during the two WRITE cycles
        samp_buf[0] = 14'h1234;
        samp_buf[1] = 14'h0005;
        rdy_low = 0;
        wr_seen = 0;
        send_frame(10'h010, 16'd2, 8'h00, 1'b0);
        check("f1_rdy_low", rdy_low, 2);
        check("f1_writes", wr_seen, 2);

        // Same frame with checksum off by one (0x5C): writes still happen, err set
        send_frame(10'h010, 16'd2, 8'hFF, 1'b0);
        @(posedge clk); #1;
        check("err_sticky", err, 1);
        send_byte(8'hA5);
        check("sync_clr_err", err, 0);

        // Address wrap 0x3FF -> 0x000, ignored high bits of SAMP_H set
        pad = 2'b11;
        samp_buf[0] = 14'h3ABC;
        samp_buf[1] = 14'h0001;
        send_frame(10'h3FF, 16'd2, 8'h00, 1'b1);

        // N=0 means a full 1024-sample table
        pad = 2'b01;
        for (int i = 0; i < 1024; i++) samp_buf[i] = 14'($urandom_range(0, 16383));
        wr_seen = 0;
        send_frame(10'h155, 16'd0, 8'h00, 1'b0);
        check("n0_writes", wr_seen, 1024);

        // Timeout after header, then a clean frame
        pad = 2'b00;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h00);
        exp_done.push_back(1'b1);
        send_byte(8'h02);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        check("tmo_lat", k, TMO + 1);
        @(posedge clk); #1;
        check("tmo_busy", busy, 0);
        samp_buf[0] = 14'h0AAA;
        samp_buf[1] = 14'h1555;
        samp_buf[2] = 14'h3FFF;
        send_frame(10'h100, 16'd3, 8'h00, 1'b0);

        // Oversized count: done+err right after CNT_L, nothing written
        wr_seen = 0;
        send_frame(10'h000, 16'h0401, 8'h00, 1'b0);
        check("bign_done", done, 1);
        check("bign_err", err, 1);
        check("bign_busy", busy, 0);
        @(posedge clk); #1;
        check("bign_writes", wr_seen, 0);

        // Garbage before sync, then reset during the WRITE cycle
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_busy", busy, 0);
        check("garbage_err", err, 1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h00); send_byte(8'h02);
        check("mid_busy", busy, 1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        check("mr_wr_en", wr_en, 0);
        check("mr_wr_addr", wr_addr, 0);
        check("mr_wr_data", wr_data, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_err", err, 0);
        check("mr_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        samp_buf[0] = 14'h2468;
        send_frame(10'h2AB, 16'd1, 8'h00, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("wr_left", exp_wr.size(), 0);
        check("done_left", exp_done.size(), 0);
        check("final_err", err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
